// File: rtl/jts16_snd_cmdfifo_if.sv
// Command/reply bus between the main CPU decoder, the sound CPU and the
// S16 sound command FIFO.
//   slave  : the FIFO's view (strobes and data in, status and data out)
//   master : the CPU-side view (the reverse directions)
// Signals:
//   main_wr/main_din        push a command word
//   main_full/main_ovf      FIFO full / sticky dropped-write flag
//   ovf_clr                 clears main_ovf
//   main_dout/main_rdy      reply word and "unread reply" flag
//   main_rd                 main CPU consumed the reply
//   snd_rd/snd_dout/snd_obf pop strobe, head word, FIFO non-empty
//   snd_wr/snd_din          load the reply latch
//   int_ack                 Z80 interrupt acknowledge
//   flush                   synchronous FIFO clear
//   int_n                   sound-CPU interrupt, active low
//   count                   entries held, 0..DEPTH
interface jts16_snd_cmdfifo_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          main_wr;
  logic [DW-1:0] main_din;
  logic          main_full;
  logic          main_ovf;
  logic          ovf_clr;
  logic [DW-1:0] main_dout;
  logic          main_rdy;
  logic          main_rd;
  logic          snd_rd;
  logic [DW-1:0] snd_dout;
  logic          snd_obf;
  logic          snd_wr;
  logic [DW-1:0] snd_din;
  logic          int_ack;
  logic          flush;
  logic          int_n;
  logic [AW:0]   count;

  modport slave (
    input  main_wr, main_din, ovf_clr, main_rd, snd_rd, snd_wr, snd_din,
           int_ack, flush,
    output main_full, main_ovf, main_dout, main_rdy, snd_dout, snd_obf,
           int_n, count
  );

  modport master (
    output main_wr, main_din, ovf_clr, main_rd, snd_rd, snd_wr, snd_din,
           int_ack, flush,
    input  main_full, main_ovf, main_dout, main_rdy, snd_dout, snd_obf,
           int_n, count
  );
endinterface

// File: rtl/jts16_snd_cmdfifo.sv
// Main-CPU to sound-CPU command mailbox: DEPTH-entry command FIFO, one-entry
// reply latch back to the main CPU, sticky overflow flag and a sound-CPU
// interrupt that is either level (FIFO non-empty) or latched (set on push,
// cleared by int_ack). All outputs are registered.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    command/reply bus, slave side (see jts16_snd_cmdfifo_if)
module jts16_snd_cmdfifo #(
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int IRQ_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jts16_snd_cmdfifo_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp, rp_inc;
  logic [AW:0]   cnt, cnt_nx;
  logic          full, obf, ovf, rdy, int_n;
  logic [DW-1:0] head, head_nx, reply;
  logic          push, pop, ovf_set, int_n_nx;

  always_comb begin
    push    = bus.main_wr && (!full || bus.snd_rd) && !bus.flush;
    pop     = bus.snd_rd && obf && !bus.flush;
    ovf_set = bus.main_wr && full && !bus.snd_rd && !bus.flush;
    rp_inc  = rp + AW'(1);

    cnt_nx = cnt;
    if (bus.flush)
      cnt_nx = '0;
    else if (push && !pop)
      cnt_nx = cnt + (AW+1)'(1);
    else if (pop && !push)
      cnt_nx = cnt - (AW+1)'(1);

    // Head register tracks mem[rp] one cycle ahead: a push into an empty
    // (or emptying) FIFO forwards main_din, a pop exposes the next slot,
    // and popping the last entry leaves the old word in place.
    head_nx = head;
    if (push && (cnt == '0 || (pop && cnt == (AW+1)'(1))))
      head_nx = bus.main_din;
    else if (pop && cnt != (AW+1)'(1))
      head_nx = mem[rp_inc];

    int_n_nx = int_n;
    if (IRQ_MODE == 0)
      int_n_nx = (cnt_nx == '0);
    else if (push)
      int_n_nx = 1'b0;
    else if (bus.int_ack)
      int_n_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rp    <= '0;
      wp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      obf   <= 1'b0;
      ovf   <= 1'b0;
      rdy   <= 1'b0;
      int_n <= 1'b1;
      head  <= '0;
      reply <= '0;
    end else begin
      if (push) begin
        mem[wp] <= bus.main_din;
        wp      <= wp + AW'(1);
      end
      if (bus.flush) begin
        rp <= '0;
        wp <= '0;
      end else if (pop) begin
        rp <= rp_inc;
      end
      cnt   <= cnt_nx;
      full  <= (cnt_nx == (AW+1)'(DEPTH));
      obf   <= (cnt_nx != '0);
      head  <= head_nx;
      int_n <= int_n_nx;

      if (ovf_set)
        ovf <= 1'b1;
      else if (bus.ovf_clr)
        ovf <= 1'b0;

      if (bus.snd_wr) begin
        reply <= bus.snd_din;
        rdy   <= 1'b1;
      end else if (bus.main_rd) begin
        rdy <= 1'b0;
      end
    end
  end

  assign bus.count     = cnt;
  assign bus.main_full = full;
  assign bus.main_ovf  = ovf;
  assign bus.main_dout = reply;
  assign bus.main_rdy  = rdy;
  assign bus.snd_dout  = head;
  assign bus.snd_obf   = obf;
  assign bus.int_n     = int_n;
endmodule

// File: tb/tb_jts16_snd_cmdfifo.sv
module tb_jts16_snd_cmdfifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic       main_wr, ovf_clr, main_rd, snd_rd, snd_wr, int_ack, flush;
  logic [7:0] main_din, snd_din;

  jts16_snd_cmdfifo_if #(.DW(8), .DEPTH(4)) bus0 ();
  jts16_snd_cmdfifo_if #(.DW(8), .DEPTH(4)) bus1 ();

  assign bus0.main_wr = main_wr;   assign bus1.main_wr = main_wr;
  assign bus0.main_din = main_din; assign bus1.main_din = main_din;
  assign bus0.ovf_clr = ovf_clr;   assign bus1.ovf_clr = ovf_clr;
  assign bus0.main_rd = main_rd;   assign bus1.main_rd = main_rd;
  assign bus0.snd_rd = snd_rd;     assign bus1.snd_rd = snd_rd;
  assign bus0.snd_wr = snd_wr;     assign bus1.snd_wr = snd_wr;
  assign bus0.snd_din = snd_din;   assign bus1.snd_din = snd_din;
  assign bus0.int_ack = int_ack;   assign bus1.int_ack = int_ack;
  assign bus0.flush = flush;       assign bus1.flush = flush;

  jts16_snd_cmdfifo #(.DW(8), .DEPTH(4), .IRQ_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  jts16_snd_cmdfifo #(.DW(8), .DEPTH(4), .IRQ_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic clr();
    main_wr = 0; ovf_clr = 0; main_rd = 0; snd_rd = 0; snd_wr = 0;
    int_ack = 0; flush = 0; main_din = '0; snd_din = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push1(input logic [7:0] d);
    clr(); main_wr = 1; main_din = d; cyc(); clr();
  endtask

  task automatic pop1();
    clr(); snd_rd = 1; cyc(); clr();
  endtask

  task automatic test_reset();
    clr(); rst_n = 0; cyc(); cyc(); rst_n = 1; cyc();
    total++; if (bus0.int_n !== 1'b1) begin bad++; $display("FAIL reset_int_n got=%b exp=1", bus0.int_n); end
    total++; if (bus1.int_n !== 1'b1) begin bad++; $display("FAIL reset_int_n1 got=%b exp=1", bus1.int_n); end
    total++; if (bus0.snd_obf !== 1'b0) begin bad++; $display("FAIL reset_obf got=%b exp=0", bus0.snd_obf); end
    total++; if (bus0.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus0.count); end
    total++; if (bus0.main_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus0.main_full); end
    total++; if (bus0.main_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus0.main_ovf); end
    total++; if (bus0.main_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", bus0.main_rdy); end
    total++; if (bus0.snd_dout !== 8'h00) begin bad++; $display("FAIL reset_snd_dout got=%h exp=00", bus0.snd_dout); end
    total++; if (bus0.main_dout !== 8'h00) begin bad++; $display("FAIL reset_main_dout got=%h exp=00", bus0.main_dout); end
  endtask

  task automatic test_order();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      push1(vals[i]);
      total++; if (bus0.count !== 3'(i + 1)) begin bad++; $display("FAIL push_count%0d got=%0d exp=%0d", i, bus0.count, i + 1); end
      total++; if (bus0.snd_dout !== 8'h11) begin bad++; $display("FAIL push_head%0d got=%h exp=11", i, bus0.snd_dout); end
    end
    total++; if (bus0.snd_obf !== 1'b1) begin bad++; $display("FAIL order_obf got=%b exp=1", bus0.snd_obf); end
    total++; if (bus0.int_n !== 1'b0) begin bad++; $display("FAIL order_int_n got=%b exp=0", bus0.int_n); end
    total++; if (bus0.main_full !== 1'b1) begin bad++; $display("FAIL order_full got=%b exp=1", bus0.main_full); end
    for (int i = 0; i < 3; i++) begin
      pop1();
      total++; if (bus0.snd_dout !== vals[i + 1]) begin bad++; $display("FAIL pop_head%0d got=%h exp=%h", i, bus0.snd_dout, vals[i + 1]); end
      total++; if (bus0.count !== 3'(3 - i)) begin bad++; $display("FAIL pop_count%0d got=%0d exp=%0d", i, bus0.count, 3 - i); end
    end
    total++; if (bus0.main_full !== 1'b0) begin bad++; $display("FAIL pop_full got=%b exp=0", bus0.main_full); end
    pop1();
    total++; if (bus0.snd_obf !== 1'b0) begin bad++; $display("FAIL empty_obf got=%b exp=0", bus0.snd_obf); end
    total++; if (bus0.int_n !== 1'b1) begin bad++; $display("FAIL empty_int_n got=%b exp=1", bus0.int_n); end
    pop1();
    total++; if (bus0.count !== 3'd0) begin bad++; $display("FAIL underflow_count got=%0d exp=0", bus0.count); end
    total++; if (bus0.snd_obf !== 1'b0) begin bad++; $display("FAIL underflow_obf got=%b exp=0", bus0.snd_obf); end
  endtask

  task automatic test_overflow();
    logic [7:0] tail [4] = '{8'h02, 8'h03, 8'h04, 8'h66};
    push1(8'h01); push1(8'h02); push1(8'h03); push1(8'h04);
    push1(8'h55);
    total++; if (bus0.main_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus0.main_ovf); end
    total++; if (bus0.count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", bus0.count); end
    total++; if (bus0.snd_dout !== 8'h01) begin bad++; $display("FAIL ovf_head got=%h exp=01", bus0.snd_dout); end
    clr(); main_wr = 1; main_din = 8'h66; snd_rd = 1; cyc(); clr();
    total++; if (bus0.count !== 3'd4) begin bad++; $display("FAIL pushpop_count got=%0d exp=4", bus0.count); end
    total++; if (bus0.main_full !== 1'b1) begin bad++; $display("FAIL pushpop_full got=%b exp=1", bus0.main_full); end
    total++; if (bus0.main_ovf !== 1'b1) begin bad++; $display("FAIL pushpop_ovf got=%b exp=1", bus0.main_ovf); end
    // Overflow on the same cycle as ovf_clr keeps the flag set.
    clr(); main_wr = 1; main_din = 8'h77; ovf_clr = 1; cyc(); clr();
    total++; if (bus0.main_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", bus0.main_ovf); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus0.snd_dout !== tail[i]) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, bus0.snd_dout, tail[i]); end
      pop1();
    end
    total++; if (bus0.count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", bus0.count); end
    clr(); ovf_clr = 1; cyc(); clr();
    total++; if (bus0.main_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", bus0.main_ovf); end
  endtask

  task automatic test_irq_latched();
    clr(); int_ack = 1; cyc(); clr();
    total++; if (bus1.int_n !== 1'b1) begin bad++; $display("FAIL irq_ack0 got=%b exp=1", bus1.int_n); end
    push1(8'hA0);
    total++; if (bus1.int_n !== 1'b0) begin bad++; $display("FAIL irq_push got=%b exp=0", bus1.int_n); end
    pop1();
    total++; if (bus1.int_n !== 1'b0) begin bad++; $display("FAIL irq_pop_keeps got=%b exp=0", bus1.int_n); end
    total++; if (bus0.int_n !== 1'b1) begin bad++; $display("FAIL level_pop got=%b exp=1", bus0.int_n); end
    clr(); int_ack = 1; cyc(); clr();
    total++; if (bus1.int_n !== 1'b1) begin bad++; $display("FAIL irq_ack got=%b exp=1", bus1.int_n); end
    clr(); main_wr = 1; main_din = 8'hB0; int_ack = 1; cyc(); clr();
    total++; if (bus1.int_n !== 1'b0) begin bad++; $display("FAIL irq_push_wins got=%b exp=0", bus1.int_n); end
    total++; if (bus1.snd_dout !== 8'hB0) begin bad++; $display("FAIL irq_head got=%h exp=b0", bus1.snd_dout); end
    pop1();
  endtask

  task automatic test_reply();
    clr(); snd_wr = 1; snd_din = 8'h5A; cyc(); clr();
    total++; if (bus0.main_dout !== 8'h5A) begin bad++; $display("FAIL reply_data got=%h exp=5a", bus0.main_dout); end
    total++; if (bus0.main_rdy !== 1'b1) begin bad++; $display("FAIL reply_rdy got=%b exp=1", bus0.main_rdy); end
    clr(); snd_wr = 1; snd_din = 8'h5B; main_rd = 1; cyc(); clr();
    total++; if (bus0.main_dout !== 8'h5B) begin bad++; $display("FAIL reply_over got=%h exp=5b", bus0.main_dout); end
    total++; if (bus0.main_rdy !== 1'b1) begin bad++; $display("FAIL reply_wr_wins got=%b exp=1", bus0.main_rdy); end
    clr(); main_rd = 1; cyc(); clr();
    total++; if (bus0.main_rdy !== 1'b0) begin bad++; $display("FAIL reply_rd got=%b exp=0", bus0.main_rdy); end
  endtask

  task automatic test_flush();
    clr(); snd_wr = 1; snd_din = 8'h77; cyc(); clr();
    push1(8'hD1); push1(8'hD2); push1(8'hD3);
    total++; if (bus0.count !== 3'd3) begin bad++; $display("FAIL preflush_count got=%0d exp=3", bus0.count); end
    clr(); flush = 1; main_wr = 1; main_din = 8'hEE; snd_rd = 1; cyc(); clr();
    total++; if (bus0.count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", bus0.count); end
    total++; if (bus0.snd_obf !== 1'b0) begin bad++; $display("FAIL flush_obf got=%b exp=0", bus0.snd_obf); end
    total++; if (bus0.main_rdy !== 1'b1) begin bad++; $display("FAIL flush_rdy got=%b exp=1", bus0.main_rdy); end
    total++; if (bus0.main_dout !== 8'h77) begin bad++; $display("FAIL flush_reply got=%h exp=77", bus0.main_dout); end
    total++; if (bus1.int_n !== 1'b0) begin bad++; $display("FAIL flush_irq_flag got=%b exp=0", bus1.int_n); end
    push1(8'hC1);
    total++; if (bus0.count !== 3'd1) begin bad++; $display("FAIL postflush_count got=%0d exp=1", bus0.count); end
    total++; if (bus0.snd_dout !== 8'hC1) begin bad++; $display("FAIL postflush_head got=%h exp=c1", bus0.snd_dout); end
  endtask

  task automatic test_async_reset();
    pop1();
    push1(8'hE1); push1(8'hE2);
    total++; if (bus0.count !== 3'd2) begin bad++; $display("FAIL prereset_count got=%0d exp=2", bus0.count); end
    clr(); main_wr = 1; main_din = 8'hE3;
    #2 rst_n = 0;
    #1;
    total++; if (bus0.count !== 3'd0) begin bad++; $display("FAIL areset_count got=%0d exp=0", bus0.count); end
    total++; if (bus0.snd_obf !== 1'b0) begin bad++; $display("FAIL areset_obf got=%b exp=0", bus0.snd_obf); end
    total++; if (bus0.int_n !== 1'b1) begin bad++; $display("FAIL areset_int_n got=%b exp=1", bus0.int_n); end
    total++; if (bus1.int_n !== 1'b1) begin bad++; $display("FAIL areset_int_n1 got=%b exp=1", bus1.int_n); end
    total++; if (bus0.snd_dout !== 8'h00) begin bad++; $display("FAIL areset_head got=%h exp=00", bus0.snd_dout); end
    total++; if (bus0.main_rdy !== 1'b0) begin bad++; $display("FAIL areset_rdy got=%b exp=0", bus0.main_rdy); end
    total++; if (bus0.main_dout !== 8'h00) begin bad++; $display("FAIL areset_reply got=%h exp=00", bus0.main_dout); end
    clr(); cyc(); rst_n = 1; cyc();
    total++; if (bus0.count !== 3'd0) begin bad++; $display("FAIL postreset_count got=%0d exp=0", bus0.count); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_irq_latched();
    test_reply();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jts16_snd_cmdfifo.md
Name: jts16_snd_cmdfifo

Overview:
Parametrised main-CPU to sound-CPU command mailbox for the S16 sound subsystem. It generalises the single-byte sound latch into a DEPTH-entry FIFO. It adds a configurable sound-CPU interrupt mode, a one-entry reply latch from the sound CPU back to the main CPU, and sticky overflow status. It sits between the main CPU bus decoder and the sound Z80 system; snd_obf and int_n replace the latch-full and IRQ signals.

Parameters:
DW, 8, data width of command and reply words
DEPTH, 4, FIFO depth in entries; power of two, 2..256
AW, $clog2(DEPTH), pointer width; derived, not overridden
IRQ_MODE, 0, 0 = level (int_n low while FIFO non-empty); 1 = latched (set on accepted write, cleared by int_ack)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
main_wr  in  1  one-cycle strobe: push main_din
main_din  in  DW  command word from main CPU
main_full  out  1  FIFO holds DEPTH entries
main_ovf  out  1  sticky: a write was dropped while full
ovf_clr  in  1  clears main_ovf
main_dout  out  DW  reply word from sound CPU
main_rdy  out  1  reply latch holds an unread word
main_rd  in  1  one-cycle strobe: main CPU consumed reply
snd_rd  in  1  one-cycle strobe: pop head entry
snd_dout  out  DW  head entry of FIFO
snd_obf  out  1  FIFO non-empty
snd_wr  in  1  one-cycle strobe: load reply latch with snd_din
snd_din  in  DW  reply word from sound CPU
int_ack  in  1  Z80 interrupt acknowledge (IORQ & M1), used in IRQ_MODE 1
flush  in  1  synchronous FIFO clear
int_n  out  1  sound-CPU interrupt, active low
count  out  AW+1  entries currently held, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous): pointers and count = 0; snd_obf = 0, main_full = 0, main_ovf = 0, main_rdy = 0, int_n = 1, snd_dout = 0, main_dout = 0. All state clears on reset, including mid-transfer.
- Storage: DEPTH×DW register array, read pointer rp[AW-1:0], write pointer wp[AW-1:0]. Pointers wrap modulo DEPTH. count is kept separately at AW+1 bits, so full vs empty is unambiguous.
- Push: main_wr && (!main_full || snd_rd) writes mem[wp] and advances wp. Result is visible next cycle: snd_obf = 1 and snd_dout = main_din when the FIFO was empty, so latency is 1 cycle.
- Pop: snd_rd && snd_obf advances rp. snd_dout is registered and shows mem[rp] for the new rp on the following cycle. snd_rd when empty is ignored; snd_dout holds its last value.
- Simultaneous push and pop: both occur and count is unchanged. When full, the pop frees the slot, so the push is accepted and no overflow is flagged. When empty, only the push occurs and count becomes 1.
- Overflow: main_wr && main_full && !snd_rd drops the data and sets main_ovf next cycle. main_ovf stays set until ovf_clr; a set on the same cycle as ovf_clr wins.
- flush: count, rp and wp return to 0 next cycle; any main_wr or snd_rd on that cycle is discarded. Reply latch, main_ovf and the IRQ flag in IRQ_MODE 1 are unaffected.
- Reply latch: snd_wr loads main_dout and sets main_rdy. main_rd clears main_rdy. If both occur on the same cycle, snd_wr wins and main_rdy stays 1. A second snd_wr overwrites the latch.
- IRQ_MODE 0: int_n = !snd_obf, registered, following snd_obf in the same cycle.
- IRQ_MODE 1: an internal flag is set on each accepted push and cleared on int_ack; a push on the same cycle wins. int_n = !flag, registered. Popping does not clear the flag.
- Status outputs are registered, with no combinational path from any input to any output.

Test Plan:
- Reset/idle: hold rst_n=0 then release -> int_n=1, snd_obf=0, count=0, main_full=0, main_ovf=0, main_rdy=0.
- Ordering with DEPTH=4: push 8'h11, 22, 33, 44 -> main_full=1, count=4. Then pop four times -> snd_dout sequence 11, 22, 33, 44 with 1-cycle update, ending with snd_obf=0.
- Overflow: with the FIFO full, push 8'h55 with no pop -> main_ovf=1 and count stays 4. With the FIFO full, push 8'h66 with a simultaneous snd_rd -> main_ovf unchanged, count=4, 66 becomes the tail. Pulse ovf_clr -> main_ovf=0.
- IRQ_MODE 1: push 8'hA0 -> int_n=0. Pop with no int_ack -> int_n stays 0. Pulse int_ack -> int_n=1. Push and int_ack on the same cycle -> int_n=0.
- Reply latch: snd_wr with 8'h5A -> main_dout=5A, main_rdy=1. snd_wr 8'h5B together with main_rd -> main_dout=5B, main_rdy=1. Then main_rd -> main_rdy=0.
- flush and async reset: with 3 entries held, pulse flush -> count=0, snd_obf=0, main_rdy preserved. With 2 entries held and a push in flight, drop rst_n mid-cycle -> all outputs return to reset values immediately.
